// File: rtl/alu_demo_defs.sv
// Shared opcode and sequencer-state definitions for the ALU demo.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package alu_demo_defs;

    // Opcodes understood by the demo ALU, cycled in this order by the sequencer
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOR = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_SLL = 3'd7;

    // Step sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CAPT = 2'd2
    } state_t;

endpackage

// File: rtl/toggle_edge_detect.sv
// Turns every level change of a registered slow clock into a one-cycle tick.
// Latency: tick is combinational in the cycle the level differs from the stored copy.
// Backpressure: none; the first cycle after reset only primes, so a high level at release is not a tick.
module toggle_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic slow_clk,
    output logic tick
);

    logic slow_q;
    logic primed;

    // Track the previous slow_clk level; arm the detector one cycle after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slow_q <= 1'b0;
            primed <= 1'b0;
        end else begin
            slow_q <= slow_clk;
            primed <= 1'b1;
        end
    end

    assign tick = primed & (slow_clk ^ slow_q);

endmodule

// File: rtl/alu_step_sequencer.sv
// Steps the demo ALU once per slow-clock toggle (or button press when paused) and latches results for display.
// Latency: request accepted at edge E0, ALU settles through E1, display registers load at E2.
// Backpressure: requests arriving while a step is in flight are dropped, never queued.
module alu_step_sequencer
    import alu_demo_defs::*;
#(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 3,
    parameter int NUM_OPS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              slow_clk,
    input  logic              run,
    input  logic              step_btn,
    input  logic              clear,
    input  logic [DATA_W-1:0] op_a_in,
    input  logic [DATA_W-1:0] op_b_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_of,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] disp_result,
    output logic [OP_W-1:0]   disp_op,
    output logic              disp_zero,
    output logic              disp_of,
    output logic [7:0]        step_cnt,
    output logic              busy
);

    localparam logic [OP_W-1:0] LAST_OP = OP_W'(NUM_OPS - 1);

    state_t          state;
    state_t          state_nxt;
    logic            tick;
    logic            req;
    logic            load;
    logic            capt;
    logic [OP_W-1:0] op_idx;

    toggle_edge_detect u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .slow_clk (slow_clk),
        .tick     (tick)
    );

    // The button only matters while paused; the slow clock only while running
    assign req  = (tick & run) | (step_btn & ~run);
    assign load = (state == S_IDLE) & req;
    assign capt = (state == S_CAPT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: IDLE waits for a request, EXEC is a pure settle cycle, CAPT returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (clear) begin
            state_nxt = S_IDLE;
        end
    end

    // Operand launch on accept, display capture and sequence advance on CAPT; clear wipes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            op_idx      <= '0;
            disp_result <= '0;
            disp_op     <= '0;
            disp_zero   <= 1'b0;
            disp_of     <= 1'b0;
            step_cnt    <= '0;
            busy        <= 1'b0;
        end else if (clear) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            op_idx      <= '0;
            disp_result <= '0;
            disp_op     <= '0;
            disp_zero   <= 1'b0;
            disp_of     <= 1'b0;
            step_cnt    <= '0;
            busy        <= 1'b0;
        end else begin
            if (load) begin
                alu_a  <= op_a_in;
                alu_b  <= op_b_in;
                alu_op <= op_idx;
                busy   <= 1'b1;
            end
            if (capt) begin
                disp_result <= alu_result;
                disp_zero   <= alu_zero;
                disp_of     <= alu_of;
                disp_op     <= alu_op;
                step_cnt    <= step_cnt + 8'd1;
                op_idx      <= (op_idx == LAST_OP) ? '0 : op_idx + OP_W'(1);
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Bench for alu_step_sequencer: randomized operands against a step-level reference model.
// Latency: display is checked three or more cycles after each request.
// Backpressure: covers dropped requests while busy, pause/step button, clear and reset.
module tb_alu_step_sequencer;
    import alu_demo_defs::*;

    localparam int NUM_OPS = 8;

    logic        clk;
    logic        rst_n;
    logic        slow_clk;
    logic        run;
    logic        step_btn;
    logic        clear;
    logic [31:0] op_a_in;
    logic [31:0] op_b_in;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_of;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] disp_result;
    logic [2:0]  disp_op;
    logic        disp_zero;
    logic        disp_of;
    logic [7:0]  step_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: what the display should show after the most recent completed step
    int          m_op;
    int          m_cnt;
    int          m_dop;
    logic [31:0] m_res;
    logic        m_zero;
    logic        m_of;

    // Behavioural demo ALU: {overflow, result}
    function automatic logic [32:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        of;
        of = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; of = (a[31] == b[31]) && (r[31] != a[31]); end
            OP_SUB: begin r = a - b; of = (a[31] != b[31]) && (r[31] != a[31]); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOR: r = ~(a | b);
            OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = a << b[4:0];
        endcase
        return {of, r};
    endfunction

    logic [32:0] alu_out;
    assign alu_out    = alu_ref(alu_op, alu_a, alu_b);
    assign alu_result = alu_out[31:0];
    assign alu_of     = alu_out[32];
    assign alu_zero   = (alu_out[31:0] == 32'd0);

    alu_step_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slow_clk    (slow_clk),
        .run         (run),
        .step_btn    (step_btn),
        .clear       (clear),
        .op_a_in     (op_a_in),
        .op_b_in     (op_b_in),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_of      (alu_of),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .disp_result (disp_result),
        .disp_op     (disp_op),
        .disp_zero   (disp_zero),
        .disp_of     (disp_of),
        .step_cnt    (step_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_op = 0; m_cnt = 0; m_dop = 0; m_res = '0; m_zero = 1'b0; m_of = 1'b0;
    endtask

    task automatic model_step(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] o;
        o      = alu_ref(3'(m_op), a, b);
        m_res  = o[31:0];
        m_of   = o[32];
        m_zero = (o[31:0] == 32'd0);
        m_dop  = m_op;
        m_op   = (m_op + 1) % NUM_OPS;
        m_cnt  = (m_cnt + 1) % 256;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; slow_clk = 1'b1; run = 1'b1; step_btn = 1'b0; clear = 1'b0;
        op_a_in = $urandom; op_b_in = $urandom;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if ({alu_op, alu_a, alu_b, disp_result, disp_op, disp_zero, disp_of, step_cnt, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: step_cnt=%0d busy=%0b alu_a=%h disp_result=%h, all must be 0",
                     step_cnt, busy, alu_a, disp_result);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || step_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_no_spurious_tick cycle %0d: busy=%0b step_cnt=%0d, need 0/0", i, busy, step_cnt);
            end
        end
    endtask

    task automatic test_basic_add();
        run = 1'b0; slow_clk = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (step_cnt !== 8'd0) begin
            errors++;
            $display("FAIL basic_paused_tick: step_cnt=%0d, need 0", step_cnt);
        end
        run = 1'b1; op_a_in = 32'd5; op_b_in = 32'd3; slow_clk = 1'b1;
        model_step(32'd5, 32'd3);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 3'd0) begin
            errors++;
            $display("FAIL basic_launch: busy=%0b alu_a=%0d alu_b=%0d alu_op=%0d, need 1/5/3/0", busy, alu_a, alu_b, alu_op);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || disp_op !== 3'(m_dop) || disp_result !== 32'd8 || step_cnt !== 8'(m_cnt)) begin
            errors++;
            $display("FAIL basic_add: busy=%0b disp_op=%0d disp_result=%0d step_cnt=%0d, need 0/%0d/8/%0d",
                     busy, disp_op, disp_result, step_cnt, m_dop, m_cnt);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] a;
        logic [31:0] b;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_clear();
        checks++;
        if (step_cnt !== 8'd0 || disp_result !== 32'd0 || disp_op !== 3'd0 || alu_a !== 32'd0) begin
            errors++;
            $display("FAIL seq_clear: step_cnt=%0d disp_result=%h disp_op=%0d alu_a=%h, need all 0",
                     step_cnt, disp_result, disp_op, alu_a);
        end
        run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a = $urandom; b = $urandom;
            if (i == 1) begin a = 32'h8000_0000; b = 32'd1; end
            if (i == 4) b = a;
            op_a_in = a; op_b_in = b; slow_clk = ~slow_clk;
            model_step(a, b);
            @(negedge clk);
            op_a_in = $urandom; op_b_in = $urandom;
            repeat (9) @(negedge clk);
            checks++;
            if (disp_op !== 3'(m_dop) || disp_result !== m_res || disp_zero !== m_zero ||
                disp_of !== m_of || step_cnt !== 8'(m_cnt) || alu_a !== a || alu_b !== b) begin
                errors++;
                $display("FAIL seq_step %0d: op=%0d res=%h z=%0b of=%0b cnt=%0d alu_a=%h, need %0d/%h/%0b/%0b/%0d/%h",
                         i, disp_op, disp_result, disp_zero, disp_of, step_cnt, alu_a,
                         m_dop, m_res, m_zero, m_of, m_cnt, a);
            end
            if (i == 1) begin
                checks++;
                if (disp_of !== 1'b1 || disp_result !== 32'h7FFF_FFFF) begin
                    errors++;
                    $display("FAIL seq_sub_overflow: of=%0b res=%h, need 1/7fffffff", disp_of, disp_result);
                end
            end
            if (i == 4) begin
                checks++;
                if (disp_zero !== 1'b1) begin
                    errors++;
                    $display("FAIL seq_xor_zero: zero=%0b, need 1", disp_zero);
                end
            end
        end
        checks++;
        if (step_cnt !== 8'd9 || disp_op !== 3'd0) begin
            errors++;
            $display("FAIL seq_wrap: step_cnt=%0d disp_op=%0d, need 9/0", step_cnt, disp_op);
        end
    endtask

    task automatic test_pause_step();
        logic [31:0] a;
        logic [31:0] b;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_clear();
        run = 1'b0;
        a = $urandom; b = $urandom; op_a_in = a; op_b_in = b;
        slow_clk = ~slow_clk; repeat (5) @(negedge clk);
        slow_clk = ~slow_clk; repeat (5) @(negedge clk);
        checks++;
        if (step_cnt !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pause_ticks: step_cnt=%0d busy=%0b, need 0/0", step_cnt, busy);
        end
        step_btn = 1'b1;
        model_step(a, b);
        @(negedge clk); step_btn = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (step_cnt !== 8'(m_cnt) || disp_op !== 3'd0 || disp_result !== m_res) begin
            errors++;
            $display("FAIL pause_button: step_cnt=%0d disp_op=%0d res=%h, need %0d/0/%h", step_cnt, disp_op, disp_result, m_cnt, m_res);
        end
        run = 1'b1; step_btn = 1'b1;
        @(negedge clk); step_btn = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (step_cnt !== 8'(m_cnt)) begin
            errors++;
            $display("FAIL button_ignored_when_running: step_cnt=%0d, need %0d", step_cnt, m_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        run = 1'b1;
        a = $urandom; b = $urandom; op_a_in = a; op_b_in = b;
        slow_clk = ~slow_clk; model_step(a, b);
        @(negedge clk);
        op_a_in = $urandom; op_b_in = $urandom; slow_clk = ~slow_clk;
        repeat (10) @(negedge clk);
        checks++;
        if (step_cnt !== 8'(m_cnt) || alu_a !== a || disp_result !== m_res || disp_op !== 3'(m_dop)) begin
            errors++;
            $display("FAIL busy_drop: step_cnt=%0d alu_a=%h res=%h op=%0d, need %0d/%h/%h/%0d",
                     step_cnt, alu_a, disp_result, disp_op, m_cnt, a, m_res, m_dop);
        end
        a = $urandom; b = $urandom; op_a_in = a; op_b_in = b;
        slow_clk = ~slow_clk; model_step(a, b);
        @(negedge clk); run = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (step_cnt !== 8'(m_cnt) || disp_result !== m_res || disp_op !== 3'(m_dop)) begin
            errors++;
            $display("FAIL run_fall_midstep: step_cnt=%0d res=%h op=%0d, need %0d/%h/%0d", step_cnt, disp_result, disp_op, m_cnt, m_res, m_dop);
        end
    endtask

    task automatic test_clear_capture();
        logic [31:0] a;
        logic [31:0] b;
        run = 1'b1;
        a = $urandom; b = $urandom; op_a_in = a; op_b_in = b;
        slow_clk = ~slow_clk;
        repeat (2) @(negedge clk);
        clear = 1'b1; slow_clk = ~slow_clk;
        @(negedge clk); clear = 1'b0;
        model_clear();
        checks++;
        if ({alu_op, alu_a, alu_b, disp_result, disp_op, disp_zero, disp_of, step_cnt, busy} !== '0) begin
            errors++;
            $display("FAIL clear_in_capture: res=%h op=%0d cnt=%0d busy=%0b alu_a=%h, need all 0", disp_result, disp_op, step_cnt, busy, alu_a);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (step_cnt !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_tick_discarded: step_cnt=%0d busy=%0b, need 0/0", step_cnt, busy);
        end
        a = $urandom; b = $urandom; op_a_in = a; op_b_in = b;
        slow_clk = ~slow_clk; model_step(a, b);
        repeat (5) @(negedge clk);
        checks++;
        if (disp_op !== 3'd0 || disp_result !== m_res || step_cnt !== 8'd1) begin
            errors++;
            $display("FAIL clear_restart: op=%0d res=%h cnt=%0d, need 0/%h/1", disp_op, disp_result, step_cnt, m_res);
        end
    endtask

    task automatic test_reset_mid();
        run = 1'b1;
        op_a_in = $urandom; op_b_in = $urandom;
        slow_clk = ~slow_clk;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({alu_op, alu_a, alu_b, disp_result, disp_op, disp_zero, disp_of, step_cnt, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: busy=%0b cnt=%0d alu_a=%h res=%h, need all 0", busy, step_cnt, alu_a, disp_result);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (step_cnt !== 8'd0 || busy !== 1'b0 || disp_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_no_capture: cnt=%0d busy=%0b res=%h, need 0/0/0", step_cnt, busy, disp_result);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_sequence();
        test_pause_step();
        test_back_to_back();
        test_clear_capture();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
